// File: rtl/pong_rally_ctrl.sv
// pong_rally_ctrl
//   Rally controller for the 18-LED Pong game. It sequences a serve, runs the
//   ball back and forth through the external ball shift register, handles
//   paddle hits and misses, and keeps both players' scores in 2-digit BCD.
//   Player 1 defends bit WIDTH-1 (the ball travels there via SHL). Player 0
//   defends bit 0 (the ball travels there via SHR).
//
// Ports
//   CLK       in   system clock
//   CLRN      in   synchronous active-low reset
//   BTN1      in   player-1 paddle, asynchronous, active-high
//   BTN0      in   player-0 paddle, asynchronous, active-high
//   SERVE     in   serve request, asynchronous, active-high
//   Q         in   ball position from the shift register (one-hot or zero)
//   DIR       in   serve direction, 1 = toward player 1 (SHL)
//   TC        in   one-cycle speed-timer tick
//   GAMEOVER  in   win detector flag, sampled in IDLE only
//   LOAD      out  load the serve pattern into the shift register
//   SHL       out  shift the ball toward player 1
//   SHR       out  shift the ball toward player 0
//   SET       out  capture the current timer count as the new, faster period
//   MAX       out  restore the slowest timer period
//   SCORE1    out  player-1 score, 2-digit BCD
//   SCORE0    out  player-0 score, 2-digit BCD
module pong_rally_ctrl #(
  parameter int WIDTH       = 18,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             CLRN,
  input  logic             BTN1,
  input  logic             BTN0,
  input  logic             SERVE,
  input  logic [WIDTH-1:0] Q,
  input  logic             DIR,
  input  logic             TC,
  input  logic             GAMEOVER,
  output logic             LOAD,
  output logic             SHL,
  output logic             SHR,
  output logic             SET,
  output logic             MAX,
  output logic [7:0]       SCORE1,
  output logic [7:0]       SCORE0
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SERVE  = 3'd1;
  localparam logic [2:0] ST_MOVE_L = 3'd2;
  localparam logic [2:0] ST_MOVE_R = 3'd3;
  localparam logic [2:0] ST_POINT  = 3'd4;
  localparam logic [2:0] ST_OVER   = 3'd5;

  // Button vector bit order: [2] = SERVE, [1] = BTN1, [0] = BTN0.
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [2:0]                  prev_q, prev_d;
  logic [2:0]                  rise;

  logic [2:0] state_q, state_d;
  logic       pt_p1_q, pt_p1_d;      // 1: the pending point goes to player 1
  logic [7:0] score1_q, score1_d;
  logic [7:0] score0_q, score0_d;

  logic load_c, shl_c, shr_c, set_c;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo >= 4'd9) begin
      lo = 4'd0;
      if (hi >= 4'd9) hi = 4'd0;
      else            hi = hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  // Synchroniser chain and edge-detect history
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {SERVE, BTN1, BTN0};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // A rise lasts exactly one cycle because prev_q catches up on the next edge.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Rally state machine and score update
  always_comb begin
    state_d  = state_q;
    pt_p1_d  = pt_p1_q;
    score1_d = score1_q;
    score0_d = score0_q;
    load_c   = 1'b0;
    shl_c    = 1'b0;
    shr_c    = 1'b0;
    set_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (GAMEOVER)     state_d = ST_OVER;
        else if (rise[2]) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        load_c  = 1'b1;
        state_d = DIR ? ST_MOVE_L : ST_MOVE_R;
      end
      ST_MOVE_L: begin
        // A miss outranks a hit: once the ball has left the board nothing saves it.
        if (Q == '0) begin
          state_d = ST_POINT;
          pt_p1_d = 1'b0;
        end else if (rise[1] && Q[WIDTH-1]) begin
          state_d = ST_MOVE_R;
          set_c   = 1'b1;
        end else begin
          shl_c = TC;
        end
      end
      ST_MOVE_R: begin
        if (Q == '0) begin
          state_d = ST_POINT;
          pt_p1_d = 1'b1;
        end else if (rise[0] && Q[0]) begin
          state_d = ST_MOVE_L;
          set_c   = 1'b1;
        end else begin
          shr_c = TC;
        end
      end
      ST_POINT: begin
        state_d = ST_IDLE;
        if (pt_p1_q) score1_d = bcd_inc(score1_q);
        else         score0_d = bcd_inc(score0_q);
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLRN) begin
      sync_q   <= '0;
      prev_q   <= '0;
      state_q  <= ST_IDLE;
      pt_p1_q  <= 1'b0;
      score1_q <= 8'h00;
      score0_q <= 8'h00;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      pt_p1_q  <= pt_p1_d;
      score1_q <= score1_d;
      score0_q <= score0_d;
    end
  end

  // Strobes are masked while CLRN is low so a reset mid-rally moves nothing.
  assign LOAD   = CLRN & load_c;
  assign SHL    = CLRN & shl_c;
  assign SHR    = CLRN & shr_c;
  assign SET    = CLRN & set_c;
  assign MAX    = ~CLRN | (state_q == ST_POINT);
  assign SCORE1 = score1_q;
  assign SCORE0 = score0_q;

endmodule
